// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the round-robin SPI write scheduler.
package spi_sched_pkg;

  typedef enum logic [2:0] {IDLE, ARB, SHIFT, HOLD, GAP} state_t;

  localparam int   HDR_BITS = 8;
  localparam int   ADR_BITS = 7;
  localparam logic WR_FLAG  = 1'b1;
  localparam int   ID_BITS  = 3;

endpackage

// File: rtl/spi_wr_scheduler_if.sv
// Requester handshake plus SPI pins of the scheduler, bundled as one interface.
interface spi_wr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int NBIT = 8
);
  import spi_sched_pkg::*;

  logic [NREQ-1:0]          req;
  logic [ADR_BITS*NREQ-1:0] adr;
  logic [NBIT*NREQ-1:0]     dat;
  logic [NREQ-1:0]          ack;
  logic                     done;
  logic [ID_BITS-1:0]       gnt_id;
  logic                     busy;
  logic                     sclk;
  logic                     mosi;
  logic                     cs;

  modport master (output req, adr, dat,
                  input  ack, done, gnt_id, busy, sclk, mosi, cs);
  modport slave  (input  req, adr, dat,
                  output ack, done, gnt_id, busy, sclk, mosi, cs);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit after ptr, with wrap-around.
module rr_arbiter
  import spi_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [ID_BITS-1:0] ptr,
  input  logic               en,
  output logic [NREQ-1:0]    grant,
  output logic [ID_BITS-1:0] grant_idx
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [ID_BITS-1:0] idx_sel;
  logic               found;
  int                 cand;

  // Scan farthest-first so the nearest requester after ptr overwrites the rest.
  always_comb begin
    idx_sel = '0;
    found   = 1'b0;
    cand    = 0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = (int'(ptr) + off) % NREQ;
      if (req[cand[IW-1:0]]) begin
        idx_sel = ID_BITS'(cand);
        found   = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
      assign grant[gi] = en && found && (idx_sel == ID_BITS'(gi));
    end
  endgenerate

  assign grant_idx = idx_sel;

endmodule

// File: rtl/spi_wr_scheduler.sv
// Round-robin SPI write master: one {1,adr,dat} frame per granted request,
// MSB first, sclk idling low and cs held high for a guard gap between frames.
module spi_wr_scheduler
  import spi_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int NBIT    = 8,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  spi_wr_scheduler_if.slave  bus
);

  localparam int L  = HDR_BITS + NBIT;
  localparam int HW = $clog2(CLK_DIV);
  localparam int BW = $clog2(L + 1);
  localparam int GW = $clog2(CS_GAP);

  localparam logic [HW-1:0] HC_LAST = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(L - 1);
  localparam logic [GW-1:0] GC_LAST = GW'(CS_GAP - 1);

  state_t             state_reg;
  logic [ID_BITS-1:0] ptr_reg;
  logic [ID_BITS-1:0] gnt_id_reg;
  logic [L-1:0]       sr_reg;
  logic [HW-1:0]      hc_reg;
  logic [BW-1:0]      bc_reg;
  logic [GW-1:0]      gc_reg;
  logic               sclk_reg;
  logic               cs_reg;
  logic               done_reg;
  logic               busy_reg;

  logic [NREQ-1:0]     grant;
  logic [ID_BITS-1:0]  grant_idx;
  logic [L-1:0]        frame_sel;
  logic [ADR_BITS-1:0] adr_arr [NREQ];
  logic [NBIT-1:0]     dat_arr [NREQ];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (bus.req),
    .ptr       (ptr_reg),
    .en        (state_reg == ARB),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign adr_arr[gi] = bus.adr[ADR_BITS*gi +: ADR_BITS];
      assign dat_arr[gi] = bus.dat[NBIT*gi +: NBIT];
    end
  endgenerate

  // One-hot grant makes an OR-mux sufficient for the frame to load.
  always_comb begin
    frame_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) frame_sel = frame_sel | {WR_FLAG, adr_arr[i], dat_arr[i]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      gnt_id_reg <= '0;
      sr_reg     <= '0;
      hc_reg     <= '0;
      bc_reg     <= '0;
      gc_reg     <= '0;
      sclk_reg   <= 1'b0;
      cs_reg     <= 1'b1;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: if (|bus.req) state_reg <= ARB;
        ARB: begin
          if (|grant) begin
            ptr_reg    <= grant_idx;
            gnt_id_reg <= grant_idx;
            sr_reg     <= frame_sel;
            busy_reg   <= 1'b1;
            cs_reg     <= 1'b0;
            hc_reg     <= '0;
            bc_reg     <= '0;
            state_reg  <= SHIFT;
          end else begin
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          if (hc_reg == HC_LAST) begin
            hc_reg   <= '0;
            sclk_reg <= !sclk_reg;
            // Falling edge: present the next bit; leave after the last one.
            if (sclk_reg) begin
              sr_reg <= {sr_reg[L-2:0], 1'b0};
              bc_reg <= bc_reg + 1'b1;
              if (bc_reg == BC_LAST) state_reg <= HOLD;
            end
          end else begin
            hc_reg <= hc_reg + 1'b1;
          end
        end
        HOLD: begin
          if (hc_reg == HC_LAST) begin
            hc_reg    <= '0;
            gc_reg    <= '0;
            cs_reg    <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= GAP;
          end else begin
            hc_reg <= hc_reg + 1'b1;
          end
        end
        GAP: begin
          if (gc_reg == GC_LAST) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            gc_reg <= gc_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ack    = grant;
  assign bus.done   = done_reg;
  assign bus.gnt_id = gnt_id_reg;
  assign bus.busy   = busy_reg | (|grant);
  assign bus.sclk   = sclk_reg;
  assign bus.mosi   = sr_reg[L-1];
  assign bus.cs     = cs_reg;

endmodule

// File: tb/tb_spi_wr_scheduler.sv
// Bench for spi_wr_scheduler: timing-formula model checked every cycle on two
// parameterisations, plus directed frames with hand-computed expectations.
module tb_spi_wr_scheduler;

  logic clk;
  logic rst_a;
  logic rst_b;

  spi_wr_scheduler_if #(.NREQ(4), .NBIT(8))  bus_a ();
  spi_wr_scheduler_if #(.NREQ(4), .NBIT(16)) bus_b ();

  spi_wr_scheduler #(.NREQ(4), .NBIT(8), .CLK_DIV(4), .CS_GAP(4)) dut_a (
    .clk (clk), .rst (rst_a), .bus (bus_a));
  spi_wr_scheduler #(.NREQ(4), .NBIT(16), .CLK_DIV(6), .CS_GAP(4)) dut_b (
    .clk (clk), .rst (rst_b), .bus (bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state per DUT
  int          m_t    [2];
  int          m_free [2];
  int          m_arb  [2];
  int          m_ptr  [2];
  int          m_gid  [2];
  logic [23:0] m_frame[2];

  // observed frame statistics and slave model per DUT
  logic        prev_cs   [2];
  logic        prev_sclk [2];
  int          cur_rises [2];
  int          cur_cslow [2];
  logic [23:0] cur_bits  [2];
  int          last_rises[2];
  int          last_cslow[2];
  logic [23:0] last_bits [2];
  int          gap_run   [2];
  int          min_gap   [2];
  bit          seen      [2];
  int          ack_total [2];
  int          done_total[2];
  int          ack_cnt   [2][4];
  logic [15:0] slv_out   [2];
  int          ack_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input int d, input logic rv, input logic [3:0] req,
                      input logic [27:0] adr, input logic [63:0] dat,
                      input logic cs, input logic sclk, input logic mosi,
                      input logic done, input logic busy,
                      input logic [3:0] ack, input logic [2:0] gnt);
    int lv, dv, nbv, rel, idx;
    logic [15:0] msk, dsl;
    logic e_cs, e_sclk, e_mosi, e_done, e_busy;
    logic [3:0] e_ack;
    logic [2:0] e_gnt;
    lv  = (d == 0) ? 16 : 24;
    dv  = (d == 0) ? 4 : 6;
    nbv = (d == 0) ? 8 : 16;
    msk = (d == 0) ? 16'h00FF : 16'hFFFF;
    e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_done = 1'b0; e_busy = 1'b0;
    e_ack = 4'b0;
    e_gnt = 3'(m_gid[d]);
    if (!rv) begin
      m_t[d] = -1; m_free[d] = cyc + 1; m_arb[d] = -1; m_ptr[d] = 0; m_gid[d] = 0;
      e_gnt = 3'd0;
    end else begin
      if (!(m_t[d] >= 0 && cyc < m_free[d])) begin
        if (m_arb[d] == cyc) begin
          m_arb[d] = -1;
          if (req != 4'b0) begin
            idx = -1;
            for (int off = 1; off <= 4; off++)
              if (idx < 0 && req[(m_ptr[d] + off) % 4]) idx = (m_ptr[d] + off) % 4;
            m_t[d]    = cyc;
            m_free[d] = cyc + 1 + (2 * lv + 1) * dv + 4;
            m_ptr[d]  = idx;
            e_ack     = 4'b0001 << idx;
            dsl       = dat[nbv*idx +: 16] & msk;
            m_frame[d] = (24'({1'b1, adr[7*idx +: 7]}) << nbv) | 24'(dsl);
          end
        end else if (req != 4'b0) begin
          m_arb[d] = cyc + 1;
        end
      end
      if (m_t[d] >= 0 && cyc < m_free[d]) begin
        rel    = cyc - m_t[d];
        e_busy = 1'b1;
        if (rel >= 1 && rel <= (2 * lv + 1) * dv) e_cs = 1'b0;
        if (rel >= 1 && rel <= 2 * lv * dv) begin
          e_sclk = (((rel - 1) / dv) % 2) == 1;
          e_mosi = m_frame[d][lv - 1 - (rel - 1) / (2 * dv)];
        end
        e_done = (rel == (2 * lv + 1) * dv + 1);
      end
    end
    chk((d == 0) ? "cycle_a" : "cycle_b",
        64'({cs, sclk, mosi, done, busy, ack, gnt}),
        64'({e_cs, e_sclk, e_mosi, e_done, e_busy, e_ack, e_gnt}));
    if (rv && m_t[d] == cyc) m_gid[d] = m_ptr[d];

    // observed statistics and addressed slave (param_adr 1 on A, 2 on B)
    if (ack != 4'b0) begin
      ack_total[d]++;
      for (int i = 0; i < 4; i++)
        if (ack[i]) begin
          ack_cnt[d][i]++;
          if (d == 0) ack_log.push_back(i);
        end
    end
    if (done) done_total[d]++;
    if (prev_cs[d] && !cs) begin
      if (seen[d] && gap_run[d] < min_gap[d]) min_gap[d] = gap_run[d];
      cur_rises[d] = 0; cur_cslow[d] = 0; cur_bits[d] = '0;
    end
    if (!cs) begin
      cur_cslow[d]++;
      gap_run[d] = 0;
      if (sclk && !prev_sclk[d]) begin
        cur_rises[d]++;
        cur_bits[d] = {cur_bits[d][22:0], mosi};
      end
    end else begin
      gap_run[d]++;
    end
    if (!prev_cs[d] && cs) begin
      last_bits[d] = cur_bits[d]; last_rises[d] = cur_rises[d]; last_cslow[d] = cur_cslow[d];
      seen[d] = 1'b1;
      if (cur_rises[d] == lv && cur_bits[d][lv-1] &&
          ((cur_bits[d] >> nbv) & 24'h7F) == ((d == 0) ? 24'd1 : 24'd2))
        slv_out[d] = 16'(cur_bits[d]) & msk;
    end
    prev_cs[d] = cs;
    prev_sclk[d] = sclk;
  endtask

  always @(negedge clk) begin
    cyc++;
    step(0, rst_a, bus_a.req, bus_a.adr, 64'(bus_a.dat), bus_a.cs, bus_a.sclk, bus_a.mosi,
         bus_a.done, bus_a.busy, bus_a.ack, bus_a.gnt_id);
    step(1, rst_b, bus_b.req, bus_b.adr, bus_b.dat, bus_b.cs, bus_b.sclk, bus_b.mosi,
         bus_b.done, bus_b.busy, bus_b.ack, bus_b.gnt_id);
  end

  task automatic wait_acks(input int d, input int n);
    int k = 0;
    while (ack_total[d] < n && k < 3000) begin @(posedge clk); k++; end
    #1;
    chk("wait_ack", 64'(ack_total[d] >= n), 64'd1);
  endtask

  task automatic wait_dones(input int d, input int n);
    int k = 0;
    while (done_total[d] < n && k < 3000) begin @(posedge clk); k++; end
    #1;
    chk("wait_done", 64'(done_total[d] >= n), 64'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    int a1;
    int k;
    for (int d = 0; d < 2; d++) begin
      m_t[d] = -1; m_free[d] = 0; m_arb[d] = -1; m_ptr[d] = 0; m_gid[d] = 0; m_frame[d] = '0;
      prev_cs[d] = 1'b1; prev_sclk[d] = 1'b0; cur_rises[d] = 0; cur_cslow[d] = 0;
      cur_bits[d] = '0; last_rises[d] = 0; last_cslow[d] = 0; last_bits[d] = '0;
      gap_run[d] = 0; min_gap[d] = 99999; seen[d] = 1'b0; ack_total[d] = 0;
      done_total[d] = 0; slv_out[d] = '0;
      for (int i = 0; i < 4; i++) ack_cnt[d][i] = 0;
    end
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.req = '0; bus_a.adr = '0; bus_a.dat = '0;
    bus_b.req = '0; bus_b.adr = '0; bus_b.dat = '0;
    wait_cycles(3);
    chk("rst_cs", 64'(bus_a.cs), 64'd1);
    chk("rst_sclk", 64'(bus_a.sclk), 64'd0);
    chk("rst_busy", 64'(bus_a.busy), 64'd0);
    chk("rst_gnt", 64'(bus_a.gnt_id), 64'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    wait_cycles(2);

    // single write to slave 1
    bus_a.adr[6:0] = 7'h01; bus_a.dat[7:0] = 8'hA5; bus_a.req = 4'b0001;
    wait_acks(0, 1); bus_a.req = '0;
    wait_dones(0, 1); wait_cycles(1);
    chk("single_bits", 64'(last_bits[0]), 64'h81A5);
    chk("single_rises", 64'(last_rises[0]), 64'd16);
    chk("single_cslow", 64'(last_cslow[0]), 64'd132);
    chk("single_slave", 64'(slv_out[0]), 64'hA5);
    chk("single_ack0", 64'(ack_cnt[0][0]), 64'd1);

    // serve requester 3 so the full sweep starts at 0
    bus_a.adr[27:21] = 7'h13; bus_a.dat[31:24] = 8'h33; bus_a.req = 4'b1000;
    wait_acks(0, 2); bus_a.req = '0;
    wait_dones(0, 2);

    // round robin with all requests held
    for (int i = 0; i < 4; i++) begin
      bus_a.adr[7*i +: 7] = 7'(8'h10 + i);
      bus_a.dat[8*i +: 8] = 8'(8'h30 + i);
    end
    bus_a.req = 4'b1111;
    wait_acks(0, 7); bus_a.req = '0;
    wait_dones(0, 7);
    chk("rr_count", 64'(ack_log.size()), 64'd7);
    for (int i = 0; i < 5; i++) chk("rr_order", 64'(ack_log[2+i]), 64'(rr_exp[i]));
    chk("rr_min_gap_ge4", 64'(min_gap[0] >= 4), 64'd1);

    // wrap priority: 2, then 0101 gives 0 before 2
    bus_a.req = 4'b0100;
    wait_acks(0, 8); bus_a.req = 4'b0101;
    wait_acks(0, 9); bus_a.req = 4'b0100;
    wait_acks(0, 10); bus_a.req = '0;
    wait_dones(0, 10);
    chk("wrap_first", 64'(ack_log[7]), 64'd2);
    chk("wrap_second", 64'(ack_log[8]), 64'd0);
    chk("wrap_third", 64'(ack_log[9]), 64'd2);

    // short req[1] pulse during a frame is ignored
    a1 = ack_cnt[0][1];
    bus_a.req = 4'b0001;
    wait_acks(0, 11); bus_a.req = '0;
    wait_cycles(20);
    bus_a.req = 4'b0010;
    wait_cycles(1);
    bus_a.req = '0;
    wait_dones(0, 11);
    wait_cycles(30);
    chk("drop_ack1", 64'(ack_cnt[0][1]), 64'(a1));
    chk("drop_acks", 64'(ack_total[0]), 64'd11);
    chk("drop_dones", 64'(done_total[0]), 64'd11);

    // reset at the 5th sclk rise of a frame aimed at slave 1
    bus_a.adr[27:21] = 7'h01; bus_a.dat[31:24] = 8'h3C; bus_a.req = 4'b1000;
    wait_acks(0, 12); bus_a.req = '0;
    k = 0;
    while (!(cur_rises[0] == 5 && !bus_a.cs) && k < 2000) begin
      @(negedge clk); #2; k++;
    end
    chk("abort_reached", 64'(cur_rises[0]), 64'd5);
    rst_a = 1'b0;
    #1;
    chk("abort_cs", 64'(bus_a.cs), 64'd1);
    chk("abort_sclk", 64'(bus_a.sclk), 64'd0);
    chk("abort_mosi", 64'(bus_a.mosi), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_a = 1'b1;
    wait_cycles(3);
    chk("abort_slave", 64'(slv_out[0]), 64'hA5);
    chk("abort_dones", 64'(done_total[0]), 64'd11);
    bus_a.dat[31:24] = 8'h5A; bus_a.req = 4'b1000;
    wait_acks(0, 13); bus_a.req = '0;
    wait_dones(0, 12); wait_cycles(1);
    chk("after_rst_slave", 64'(slv_out[0]), 64'h5A);
    chk("after_rst_rises", 64'(last_rises[0]), 64'd16);

    // 16-bit data, CLK_DIV 6
    bus_b.adr[6:0] = 7'h02; bus_b.dat[15:0] = 16'hBEEF; bus_b.req = 4'b0001;
    wait_acks(1, 1); bus_b.req = '0;
    wait_dones(1, 1); wait_cycles(1);
    chk("wide_bits", 64'(last_bits[1]), 64'h82BEEF);
    chk("wide_rises", 64'(last_rises[1]), 64'd24);
    chk("wide_cslow", 64'(last_cslow[1]), 64'd294);
    chk("wide_slave", 64'(slv_out[1]), 64'hBEEF);

    wait_cycles(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_wr_scheduler.md
Name: spi_wr_scheduler

Overview:
- Round-robin SPI write master that shares one SPI bus among NREQ requesters.
- Each request is serialised as one write frame: an 8-bit header {1'b1, adr[6:0]}, then NBIT data bits, MSB first.
- Frames target the addressed register slaves on the board SPI chain.
- Sits between the control/ETH command logic and the register slaves. Slaves sample mosi on sclk rising edges through a 3-flop synchroniser and latch data when cs rises.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NBIT, 8, data bits per frame; must equal the slave Nbit.
- CLK_DIV, 4, clk cycles per sclk half-period; minimum 4 so slave synchronisers see every edge.
- CS_GAP, 4, minimum clk cycles cs is held high between frames (minimum 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester write request; level, held until ack.
- adr  in  7*NREQ  slave address per requester; slice i = adr[7*i+6:7*i].
- dat  in  NBIT*NREQ  write data per requester; slice i.
- ack  out  NREQ  one-cycle pulse on grant; adr/dat are captured in that cycle.
- done  out  1  one-cycle pulse in the cycle cs rises at the end of a frame.
- gnt_id  out  3  index of the requester currently or last served.
- busy  out  1  high from the grant cycle through the end of GAP.
- sclk  out  1  SPI clock; idles low.
- mosi  out  1  SPI data out; idles 0.
- cs  out  1  SPI chip select, active low; idles 1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cs=1, sclk=0, mosi=0, ack=0, done=0, busy=0, gnt_id=0.
  - Round-robin pointer = 0; shift register cleared.
- Reset mid-frame:
  - cs rises immediately and the frame is abandoned. No done, no ack.
  - The slave does not latch, because its bit counter is below NBIT+8.
- States: IDLE -> ARB -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: if any req bit is high, go to ARB next cycle.
- ARB (1 cycle):
  - Grant the first set req bit searching from ptr+1 upward, with wrap-around.
  - Set ptr = granted index, gnt_id = index, and pulse ack[index].
  - Load shift register {1'b1, adr_i, dat_i} (8+NBIT bits). Set busy=1.
  - If req dropped between IDLE and ARB, return to IDLE with no ack.
- SHIFT:
  - On entry, cs=0 and mosi = MSB, with sclk low.
  - sclk toggles every CLK_DIV cycles: low for CLK_DIV, then high for CLK_DIV.
  - mosi changes only in the cycle sclk falls, and on SHIFT entry.
  - Exactly L = 8+NBIT rising edges per frame. After the L-th falling edge, go to HOLD.
- HOLD: sclk=0 for CLK_DIV cycles, then cs=1 and pulse done; go to GAP.
- GAP: cs=1 for CS_GAP cycles, then go to IDLE and drop busy.
- Timing, with grant in cycle T:
  - cs falls at T+1.
  - k-th sclk rise (k=1..L) at T+1+(2k-1)*CLK_DIV.
  - cs rises at T+1+(2L+1)*CLK_DIV.
  - Next grant no earlier than cs rise + CS_GAP + 1.
- Arbitration details:
  - Fairness: after serving i, i has lowest priority next.
  - req changes during a frame are ignored until the next ARB.
  - A req asserted in the same cycle as done is served after GAP.
  - All-zero req stays in IDLE indefinitely.
- Counters: half-period counter width = clog2(CLK_DIV); bit counter width = clog2(8+NBIT+1). Neither counter wraps; each is reloaded explicitly.

Decomposition:
- Package spi_sched_pkg:
  - State enum {IDLE, ARB, SHIFT, HOLD, GAP}.
  - HDR_BITS=8, ADR_BITS=7, WR_FLAG=1'b1.
- Sub-module rr_arbiter (NREQ): inputs req, ptr, en; outputs one-hot grant and grant index, combinational with the registered ptr held in the parent.

Test Plan:
- Single write: req[0]=1, adr0=7'h01, dat0=8'hA5, CLK_DIV=4 -> ack[0] one pulse; mosi sampled at sclk rises = 1000_0001_1010_0101; exactly 16 rises; cs low for 132 cycles; done one pulse; the slave model with param_adr=1 outputs 8'hA5.
- Round-robin: req=4'b1111 held, distinct adr/dat -> grants in order 0,1,2,3,0; cs-high gap of at least 4 cycles between frames; gnt_id matches each frame's header.
- Wrap priority: serve req[2], then assert req=4'b0101 -> next grant is 0, then 2.
- Request drop: pulse req[1] for one cycle while a frame is in progress -> no ack[1], no extra frame.
- Reset mid-frame: rst=0 at the 5th sclk rise -> cs=1, sclk=0, mosi=0 asynchronously; the slave output is unchanged; after release, a new request frame completes normally.
- Parameter sweep: NBIT=16, CLK_DIV=6 -> 24 rises; cs low for (2*24+1)*6 = 294 cycles; the 16-bit slave latches the data correctly.
